// File: rtl/mac_rx_framer.sv
// GMII receive framer: strips preamble/SFD, streams the payload with the 4 FCS
// bytes held back, and reports CRC-32 and length status on the last payload byte.
module mac_rx_framer #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_eth_rxdv,
    input  logic        i_eth_rxer,
    input  logic [7:0]  i_eth_rxd,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_crc_ok,
    output logic        o_err,
    output logic [15:0] o_frame_len
);

    typedef enum logic [1:0] {IDLE, PRE, DATA, SKIP} state_t;

    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE = 8'hD5;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_RES  = 32'hDEBB20E3;

    // Handshake: none. Every o_valid beat is a single-cycle pulse the consumer
    // must take; there is no ready and the PHY side cannot be stalled.

    state_t      state_q, state_d;
    logic        accept, sfd_hit, eof_hit;

    logic [31:0] sr_q;       // last four accepted bytes, newest in [7:0]
    logic [2:0]  sr_cnt_q;
    logic [7:0]  h_q;
    logic        h_full_q;
    logic        first_q;
    logic [31:0] crc_q;
    logic [15:0] cnt_q;
    logic        err_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_eth_rxdv) state_d = (i_eth_rxd == PRE_BYTE) ? PRE : SKIP;
            PRE: begin
                if (!i_eth_rxdv)                 state_d = IDLE;
                else if (i_eth_rxd == SFD_BYTE)  state_d = DATA;
                else if (i_eth_rxd != PRE_BYTE)  state_d = SKIP;
            end
            DATA: if (!i_eth_rxdv) state_d = IDLE;
            SKIP: if (!i_eth_rxdv) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        sfd_hit = 1'b0;
        eof_hit = 1'b0;
        case (state_q)
            PRE:  sfd_hit = i_eth_rxdv && (i_eth_rxd == SFD_BYTE);
            DATA: begin
                accept  = i_eth_rxdv;
                eof_hit = !i_eth_rxdv;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q        <= '0;
            sr_cnt_q    <= '0;
            h_q         <= '0;
            h_full_q    <= 1'b0;
            first_q     <= 1'b0;
            crc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_crc_ok    <= 1'b0;
            o_err       <= 1'b0;
            o_frame_len <= '0;
        end else begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eof   <= 1'b0;

            if (sfd_hit) begin
                crc_q    <= 32'hFFFF_FFFF;
                cnt_q    <= '0;
                err_q    <= 1'b0;
                sr_cnt_q <= '0;
                h_full_q <= 1'b0;
                first_q  <= 1'b1;
            end

            if (accept) begin
                crc_q <= crc_byte(crc_q, i_eth_rxd);
                if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
                if (i_eth_rxer) err_q <= 1'b1;
                sr_q <= {sr_q[23:0], i_eth_rxd};
                if (sr_cnt_q == 3'd4) begin
                    h_q      <= sr_q[31:24];
                    h_full_q <= 1'b1;
                    // H is overwritten this cycle, so its old byte is now known to be payload
                    if (h_full_q) begin
                        o_valid <= 1'b1;
                        o_data  <= h_q;
                        o_sof   <= first_q;
                        first_q <= 1'b0;
                    end
                end else begin
                    sr_cnt_q <= sr_cnt_q + 3'd1;
                end
            end

            if (eof_hit) begin
                sr_cnt_q <= '0;
                h_full_q <= 1'b0;
                if (h_full_q) begin
                    o_valid     <= 1'b1;
                    o_eof       <= 1'b1;
                    o_data      <= h_q;
                    o_sof       <= first_q;
                    first_q     <= 1'b0;
                    o_frame_len <= cnt_q - 16'd4;
                    o_crc_ok    <= (crc_q == CRC_RES);
                    o_err       <= err_q || (32'(cnt_q) < MIN_FRAME) || (32'(cnt_q) > MAX_FRAME);
                end
            end
        end
    end

endmodule

// File: doc/mac_rx_framer.md
Name: mac_rx_framer

Overview:
- GMII receive framer: the receive-side counterpart of the MAC transmit path. It takes raw GMII receive bytes and strips the preamble and SFD.
- Streams the frame payload (destination MAC through last byte before FCS) to the user side with start/end markers, withholding the 4 FCS bytes.
- Checks the IEEE 802.3 CRC-32 and frame length, and reports status on the last payload byte.
- Sits between the PHY receive pins and the receive buffer, on the receive clock.

Parameters:
- MIN_FRAME, 64, minimum legal frame length in bytes, FCS included.
- MAX_FRAME, 1518, maximum legal frame length in bytes, FCS included.

Ports:
- i_clk  input  1  GMII receive clock, 125 MHz.
- i_rst_n  input  1  reset.
- i_eth_rxdv  input  1  GMII receive data valid.
- i_eth_rxer  input  1  GMII receive error.
- i_eth_rxd  input  8  GMII receive data.
- o_data  output  8  payload byte.
- o_valid  output  1  o_data valid this cycle.
- o_sof  output  1  first payload byte, qualified by o_valid.
- o_eof  output  1  last payload byte, qualified by o_valid.
- o_crc_ok  output  1  FCS correct; meaningful only with o_eof.
- o_err  output  1  rxer seen, or length outside [MIN_FRAME, MAX_FRAME]; meaningful only with o_eof.
- o_frame_len  output  16  payload byte count (FCS excluded); meaningful only with o_eof.

Behaviour:
- Clocking and reset: one clock i_clk. Reset i_rst_n is asynchronous, active-low. All outputs register-driven; on reset all outputs = 0, state = IDLE, internal buffers and counters cleared.
- Reset mid-frame: the partial frame is discarded with no eof. The framer resynchronises on the next rising rxdv.
- State machine:
  - IDLE: rxdv=1 and rxd=0x55 -> PRE. rxdv=1 and any other byte -> SKIP.
  - PRE: rxdv=0 -> IDLE. rxd=0x55 -> stay. rxd=0xD5 -> DATA; CRC register := 0xFFFFFFFF, byte count := 0, error flag := 0. Any other byte -> SKIP.
  - DATA: each cycle with rxdv=1 accepts one byte. rxdv=0 -> IDLE and performs the end-of-frame action below.
  - SKIP: wait for rxdv=0 -> IDLE. Produces no output.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, LSB first.
  - Updated on every accepted DATA byte, FCS bytes included.
  - At end of frame, o_crc_ok = 1 iff the register equals the residue 0xDEBB20E3.
- Byte count: increments per accepted byte, saturating at 0xFFFF.
- FCS holdback:
  - 4-byte shift register plus a 1-byte hold register H with a flag.
  - Each accepted byte shifts in. When 4 bytes were already present, the oldest moves to H.
  - If H was already full before that move, the old H is emitted on the next clock: o_valid=1, o_eof=0. o_sof=1 iff it is payload byte 0.
  - Result: payload byte k appears on o_data one clock after byte k+5 (k+1 after SFD counting) is sampled.
- End of frame (first rxdv=0 cycle in DATA):
  - If H is full, emit H on the next clock with o_valid=1, o_eof=1, o_frame_len = count-4, o_crc_ok as above. o_err = 1 if rxer was seen in DATA, count < MIN_FRAME, or count > MAX_FRAME.
  - If H is empty (fewer than 5 bytes after SFD), emit nothing.
  - A frame with exactly 5 bytes after SFD gives o_sof=o_eof=1 on the same beat.
- rxer: sampled only in DATA while rxdv=1; sets the sticky error flag. The data byte is still accepted.
- Over-length frames keep streaming, with o_err at eof.
- o_sof, o_eof, o_valid are single-cycle pulses. o_data, o_crc_ok, o_err, o_frame_len hold their last values when o_valid=0.
- No backpressure: the consumer must accept every o_valid beat.
- Back-to-back frames: the minimum 1-cycle rxdv low gap is supported. The eof beat of frame N precedes any beat of frame N+1.

Test Plan:
- Good minimum frame: 7x0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct FCS -> 60 o_valid beats with data 0x00..0x3B; o_sof on 0x00, o_eof on 0x3B; o_frame_len=60, o_crc_ok=1, o_err=0.
- Same frame with payload byte 10 flipped to 0xFF -> 60 beats, byte 10 = 0xFF, o_crc_ok=0, o_err=0.
- Same good frame with i_eth_rxer=1 for one cycle at payload byte 30 -> 60 beats, o_crc_ok=1, o_err=1.
- Runt: 20-byte payload + correct FCS -> 20 beats, o_frame_len=20, o_crc_ok=1, o_err=1. Then a 1-byte payload + FCS -> single beat with o_sof=o_eof=1, o_frame_len=1. Then 3 bytes after SFD -> no output at all.
- Bad preamble: 0x55,0x55,0x12,... for 70 cycles -> no o_valid. Next good 64-byte frame after a 1-cycle gap -> received correctly, o_frame_len=60.
- Reset: i_rst_n low for 2 cycles during payload byte 25 of a 1000-byte frame -> all outputs 0 immediately, no o_eof. Subsequent 1514-byte payload frame (1518 with FCS) -> 1514 beats, o_frame_len=1514, o_crc_ok=1, o_err=0. A 1515-byte payload -> o_err=1.
